// File: rtl/fft16_pkg.sv
// fft16_pkg: shared types, sizes, twiddle ROM and helpers for the 16-point FFT.
// Used by fft16_ctrl, fft16_addr_gen, fft16_ctrl_if and the butterfly PE.
package fft16_pkg;

    localparam int N     = 16;
    localparam int LOG2N = 4;

    typedef enum logic [1:0] {
        LOAD,
        ISSUE,
        WAIT,
        OUT
    } state_t;

    // Real part of W16^k = cos(2*pi*k/16), Q16.16 signed.
    function automatic logic [31:0] tw_re(input logic [2:0] k);
        logic [31:0] w;
        unique case (k)
            3'd0:    w = 32'h0001_0000;
            3'd1:    w = 32'h0000_EC83;
            3'd2:    w = 32'h0000_B505;
            3'd3:    w = 32'h0000_61F8;
            3'd4:    w = 32'h0000_0000;
            3'd5:    w = 32'hFFFF_9E08;
            3'd6:    w = 32'hFFFF_4AFB;
            default: w = 32'hFFFF_137D;
        endcase
        return w;
    endfunction

    // Imaginary part of W16^k = -sin(2*pi*k/16), Q16.16 signed.
    function automatic logic [31:0] tw_im(input logic [2:0] k);
        logic [31:0] w;
        unique case (k)
            3'd0:    w = 32'h0000_0000;
            3'd1:    w = 32'hFFFF_9E08;
            3'd2:    w = 32'hFFFF_4AFB;
            3'd3:    w = 32'hFFFF_137D;
            3'd4:    w = 32'hFFFF_0000;
            3'd5:    w = 32'hFFFF_137D;
            3'd6:    w = 32'hFFFF_4AFB;
            default: w = 32'hFFFF_9E08;
        endcase
        return w;
    endfunction

    function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/fft16_ctrl_if.sv
// fft16_ctrl_if: sample input, PE launch/return and result output bundle.
// master = controller side, slave = front end, PE and output stage.
interface fft16_ctrl_if;
    import fft16_pkg::*;

    logic             in_valid;
    logic [15:0]      in_data;
    logic             in_ready;
    logic             pe_ab_valid;
    logic [31:0]      pe_a;
    logic [31:0]      pe_b;
    logic [31:0]      pe_const_real;
    logic [31:0]      pe_const_imag;
    logic [31:0]      pe_fft_a;
    logic [31:0]      pe_fft_b;
    logic             pe_valid;
    logic             out_valid;
    logic [31:0]      out_data;
    logic [LOG2N-1:0] out_index;
    logic             done;

    modport master (
        input  in_valid, in_data, pe_fft_a, pe_fft_b, pe_valid,
        output in_ready, pe_ab_valid, pe_a, pe_b,
        output pe_const_real, pe_const_imag,
        output out_valid, out_data, out_index, done
    );

    modport slave (
        output in_valid, in_data, pe_fft_a, pe_fft_b, pe_valid,
        input  in_ready, pe_ab_valid, pe_a, pe_b,
        input  pe_const_real, pe_const_imag,
        input  out_valid, out_data, out_index, done
    );

endinterface

// File: rtl/fft16_addr_gen.sv
// fft16_addr_gen: maps (stage, butterfly) to DIF operand addresses and twiddle k.
// Purely combinational; span halves every stage.
module fft16_addr_gen
    import fft16_pkg::*;
(
    input  logic [1:0] stage,
    input  logic [2:0] bf,
    output logic [3:0] top,
    output logic [3:0] bot,
    output logic [2:0] k
);

    logic [3:0] span;
    logic [2:0] mask;
    logic [2:0] pos;
    logic [3:0] grp;

    // top = 2*span*group + pos, bot = top + span, k = pos << stage
    always_comb begin
        span = 4'd8 >> stage;
        mask = 3'b111 >> stage;
        pos  = bf & mask;
        grp  = {1'b0, bf >> (2'd3 - stage)};
        top  = (grp << (3'd4 - {1'b0, stage})) | {1'b0, pos};
        bot  = top + span;
        k    = pos << stage;
    end

endmodule

// File: rtl/fft16_pe.sv
// fft16_pe: radix-2 DIF butterfly, fixed 3-cycle latency, 16-bit wrap arithmetic.
// fft_a = a+b, fft_b = (a-b)*W with the product truncated to bits [31:16].
module fft16_pe (
    input  logic        clk,
    input  logic        rst,
    input  logic        ab_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] w_re,
    input  logic [31:0] w_im,
    output logic [31:0] fft_a,
    output logic [31:0] fft_b,
    output logic        valid
);

    logic signed [15:0] dr16, di16;
    logic signed [31:0] dr, di, wr, wi, pr, pi;
    logic [31:0] sum, prod;
    logic [2:0]  v;
    logic [31:0] ra [3];
    logic [31:0] rb [3];

    // butterfly arithmetic; low 32 bits of the product suffice for [31:16]
    always_comb begin
        dr16 = a[31:16] - b[31:16];
        di16 = a[15:0] - b[15:0];
        dr   = 32'(dr16);
        di   = 32'(di16);
        wr   = w_re;
        wi   = w_im;
        pr   = dr * wr - di * wi;
        pi   = dr * wi + di * wr;
        sum  = {a[31:16] + b[31:16], a[15:0] + b[15:0]};
        prod = {16'(pr >> 16), 16'(pi >> 16)};
    end

    // three-deep result pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < 3; i++) begin
                ra[i] <= '0;
                rb[i] <= '0;
            end
        end else begin
            v     <= {v[1:0], ab_valid};
            ra[0] <= sum;
            rb[0] <= prod;
            ra[1] <= ra[0];
            rb[1] <= rb[0];
            ra[2] <= ra[1];
            rb[2] <= rb[1];
        end
    end

    assign fft_a = ra[2];
    assign fft_b = rb[2];
    assign valid = v[2];

endmodule

// File: rtl/fft16_ctrl.sv
// fft16_ctrl: 16-point DIF FFT sequencer for a shared butterfly PE.
// Option FFT16_CTRL_BITREV_EN: emit results in natural order.
module fft16_ctrl
    import fft16_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fft16_ctrl_if.master bus
);

    state_t           state, state_nx;
    logic [LOG2N-1:0] cnt;
    logic [1:0]       stage;
    logic [2:0]       bf;
    logic [31:0]      mem [N];
    logic [3:0]       top, bot;
    logic [2:0]       k;
    logic             last_bf;

    fft16_addr_gen u_addr (
        .stage (stage),
        .bf    (bf),
        .top   (top),
        .bot   (bot),
        .k     (k)
    );

    assign last_bf = (stage == 2'd3) && (bf == 3'd7);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_nx;
    end

    // next-state decode
    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:  if (bus.in_valid && cnt == 4'd15) state_nx = ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT:  if (bus.pe_valid) state_nx = last_bf ? OUT : ISSUE;
            OUT:   if (cnt == 4'd15) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    // sample capture, in-place write-back and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            stage <= '0;
            bf    <= '0;
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else begin
            unique case (state)
                LOAD: if (bus.in_valid) begin
                    mem[cnt] <= {bus.in_data, 16'h0000};
                    cnt      <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        stage <= '0;
                        bf    <= '0;
                    end
                end
                WAIT: if (bus.pe_valid) begin
                    mem[top] <= bus.pe_fft_a;
                    mem[bot] <= bus.pe_fft_b;
                    bf       <= bf + 3'd1;
                    if (bf == 3'd7) stage <= stage + 2'd1;
                end
                OUT: cnt <= cnt + 4'd1;
                default: ;
            endcase
        end
    end

    // outputs; operands stay on the bus through WAIT
    always_comb begin
        bus.in_ready      = 1'b0;
        bus.pe_ab_valid   = 1'b0;
        bus.pe_a          = '0;
        bus.pe_b          = '0;
        bus.pe_const_real = '0;
        bus.pe_const_imag = '0;
        bus.out_valid     = 1'b0;
        bus.out_data      = '0;
        bus.out_index     = '0;
        bus.done          = 1'b0;
        unique case (state)
            LOAD: bus.in_ready = 1'b1;
            ISSUE, WAIT: begin
                bus.pe_ab_valid   = (state == ISSUE);
                bus.pe_a          = mem[top];
                bus.pe_b          = mem[bot];
                bus.pe_const_real = tw_re(k);
                bus.pe_const_imag = tw_im(k);
            end
            OUT: begin
                bus.out_valid = 1'b1;
`ifdef FFT16_CTRL_BITREV_EN
                bus.out_data  = mem[bitrev4(cnt)];
                bus.out_index = cnt;
`else
                bus.out_data  = mem[cnt];
                bus.out_index = bitrev4(cnt);
`endif
                bus.done      = (cnt == 4'd15);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fft16_ctrl.sv
// tb_fft16_ctrl: directed bench for fft16_ctrl with the butterfly PE attached.
// Works with and without FFT16_CTRL_BITREV_EN.
module tb_fft16_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    fft16_ctrl_if bus ();

    fft16_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fft16_pe u_pe (
        .clk      (clk),
        .rst      (rst),
        .ab_valid (bus.pe_ab_valid),
        .a        (bus.pe_a),
        .b        (bus.pe_b),
        .w_re     (bus.pe_const_real),
        .w_im     (bus.pe_const_imag),
        .fft_a    (bus.pe_fft_a),
        .fft_b    (bus.pe_fft_b),
        .valid    (bus.pe_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] w_re_tab [8] = '{
        32'h00010000, 32'h0000EC83, 32'h0000B505, 32'h000061F8,
        32'h00000000, 32'hFFFF9E08, 32'hFFFF4AFB, 32'hFFFF137D
    };
    logic [31:0] w_im_tab [8] = '{
        32'h00000000, 32'hFFFF9E08, 32'hFFFF4AFB, 32'hFFFF137D,
        32'hFFFF0000, 32'hFFFF137D, 32'hFFFF4AFB, 32'hFFFF9E08
    };
    int k_tab [32] = '{
        0, 1, 2, 3, 4, 5, 6, 7,
        0, 2, 4, 6, 0, 2, 4, 6,
        0, 4, 0, 4, 0, 4, 0, 4,
        0, 0, 0, 0, 0, 0, 0, 0
    };

    logic [15:0] smp   [16];
    logic [31:0] exp_x [16];
    logic [31:0] o_data [$];
    logic [3:0]  o_idx  [$];
    int          o_cyc  [$];
    int          iss_cyc [$];
    logic [31:0] iss_re [$];
    logic [31:0] iss_im [$];
    int          l_cyc;
    int          done_cyc;
    bit          got_done;
    logic        rdy_after;

    function automatic logic [3:0] exp_idx(input int j);
        logic [3:0] v;
        v = j[3:0];
`ifdef FFT16_CTRL_BITREV_EN
        return v;
`else
        return {v[0], v[1], v[2], v[3]};
`endif
    endfunction

    task automatic set_impulse();
        for (int i = 0; i < 16; i++) begin
            smp[i]   = (i == 0) ? 16'h0100 : 16'h0000;
            exp_x[i] = 32'h01000000;
        end
    endtask

    task automatic set_dc();
        for (int i = 0; i < 16; i++) begin
            smp[i]   = 16'h0100;
            exp_x[i] = (i == 0) ? 32'h10000000 : 32'h0;
        end
    endtask

    task automatic set_alt();
        for (int i = 0; i < 16; i++) begin
            smp[i]   = i[0] ? 16'hFF00 : 16'h0100;
            exp_x[i] = (i == 8) ? 32'h10000000 : 32'h0;
        end
    endtask

    task automatic load_frame();
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = smp[i];
            @(posedge clk);
            #1;
        end
        l_cyc = cyc - 1;
    endtask

    task automatic run_frame(input bit hold);
        o_data.delete();
        o_idx.delete();
        o_cyc.delete();
        iss_cyc.delete();
        iss_re.delete();
        iss_im.delete();
        got_done = 1'b0;
        done_cyc = -1;
        load_frame();
        bus.in_valid = hold;
        bus.in_data  = 16'h7FFF;
        for (int t = 0; t < 200 && !got_done; t++) begin
            if (bus.pe_ab_valid) begin
                iss_cyc.push_back(cyc);
                iss_re.push_back(bus.pe_const_real);
                iss_im.push_back(bus.pe_const_imag);
            end
            if (bus.out_valid) begin
                o_data.push_back(bus.out_data);
                o_idx.push_back(bus.out_index);
                o_cyc.push_back(cyc);
            end
            if (bus.done) begin
                got_done = 1'b1;
                done_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        rdy_after    = bus.in_ready;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        else n_pass++;
        n_total++;
        if (bus.pe_ab_valid !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL reset_strobes: ab=%b ov=%b done=%b want 0", bus.pe_ab_valid, bus.out_valid, bus.done);
        else n_pass++;
        n_total++;
        if (bus.pe_a !== 32'h0 || bus.pe_b !== 32'h0 || bus.pe_const_real !== 32'h0)
            $display("FAIL reset_pe_bus: a=%h b=%h wr=%h want 0", bus.pe_a, bus.pe_b, bus.pe_const_real);
        else n_pass++;
        n_total++;
        if (bus.out_data !== 32'h0 || bus.out_index !== 4'h0)
            $display("FAIL reset_out: data=%h idx=%h want 0", bus.out_data, bus.out_index);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_impulse();
        set_impulse();
        run_frame(1'b0);
        n_total++;
        if (o_data.size() != 16)
            $display("FAIL impulse_count: got %0d want 16", o_data.size());
        else begin
            n_pass++;
            for (int j = 0; j < 16; j++) begin
                n_total++;
                if (o_idx[j] !== exp_idx(j) || o_data[j] !== exp_x[exp_idx(j)])
                    $display("FAIL impulse_out%0d: idx=%h data=%h want idx=%h data=%h", j, o_idx[j], o_data[j], exp_idx(j), exp_x[exp_idx(j)]);
                else n_pass++;
            end
            n_total++;
            if (o_cyc[0] != l_cyc + 129 || o_cyc[15] != l_cyc + 144)
                $display("FAIL impulse_out_window: got %0d..%0d want %0d..%0d", o_cyc[0] - l_cyc, o_cyc[15] - l_cyc, 129, 144);
            else n_pass++;
        end
        n_total++;
        if (!got_done || done_cyc != l_cyc + 144)
            $display("FAIL impulse_done_cycle: got L+%0d want L+144", done_cyc - l_cyc);
        else n_pass++;
        n_total++;
        if (rdy_after !== 1'b1)
            $display("FAIL impulse_ready_after: got %b want 1", rdy_after);
        else n_pass++;
    endtask

    task automatic test_dc();
        set_dc();
        run_frame(1'b0);
        n_total++;
        if (o_data.size() != 16)
            $display("FAIL dc_count: got %0d want 16", o_data.size());
        else begin
            n_pass++;
            for (int j = 0; j < 16; j++) begin
                n_total++;
                if (o_idx[j] !== exp_idx(j) || o_data[j] !== exp_x[exp_idx(j)])
                    $display("FAIL dc_out%0d: idx=%h data=%h want idx=%h data=%h", j, o_idx[j], o_data[j], exp_idx(j), exp_x[exp_idx(j)]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_alternating();
        set_alt();
        run_frame(1'b0);
        n_total++;
        if (o_data.size() != 16)
            $display("FAIL alt_count: got %0d want 16", o_data.size());
        else begin
            n_pass++;
            for (int j = 0; j < 16; j++) begin
                n_total++;
                if (o_idx[j] !== exp_idx(j) || o_data[j] !== exp_x[exp_idx(j)])
                    $display("FAIL alt_out%0d: idx=%h data=%h want idx=%h data=%h", j, o_idx[j], o_data[j], exp_idx(j), exp_x[exp_idx(j)]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_protocol();
        set_dc();
        run_frame(1'b1);
        n_total++;
        if (o_data.size() != 16)
            $display("FAIL proto_count: got %0d want 16", o_data.size());
        else begin
            n_pass++;
            for (int j = 0; j < 16; j++) begin
                n_total++;
                if (o_data[j] !== exp_x[exp_idx(j)])
                    $display("FAIL proto_out%0d: data=%h want %h", j, o_data[j], exp_x[exp_idx(j)]);
                else n_pass++;
            end
        end
        n_total++;
        if (iss_cyc.size() != 32)
            $display("FAIL proto_issues: got %0d want 32", iss_cyc.size());
        else begin
            n_pass++;
            for (int i = 0; i < 32; i++) begin
                n_total++;
                if (iss_cyc[i] != l_cyc + 1 + 4 * i)
                    $display("FAIL proto_issue%0d_cycle: got L+%0d want L+%0d", i, iss_cyc[i] - l_cyc, 1 + 4 * i);
                else n_pass++;
                n_total++;
                if (iss_re[i] !== w_re_tab[k_tab[i]] || iss_im[i] !== w_im_tab[k_tab[i]])
                    $display("FAIL proto_issue%0d_twiddle: got %h/%h want %h/%h", i, iss_re[i], iss_im[i], w_re_tab[k_tab[i]], w_im_tab[k_tab[i]]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        set_dc();
        load_frame();
        bus.in_valid = 1'b0;
        repeat (59) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        n_total++;
        if (bus.in_ready !== 1'b1 || bus.pe_ab_valid !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL midreset_ctrl: rdy=%b ab=%b ov=%b done=%b want 1/0/0/0", bus.in_ready, bus.pe_ab_valid, bus.out_valid, bus.done);
        else n_pass++;
        n_total++;
        if (bus.pe_a !== 32'h0 || bus.pe_b !== 32'h0 || bus.pe_const_imag !== 32'h0 || bus.out_data !== 32'h0)
            $display("FAIL midreset_data: a=%h b=%h wi=%h od=%h want 0", bus.pe_a, bus.pe_b, bus.pe_const_imag, bus.out_data);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        set_impulse();
        run_frame(1'b0);
        n_total++;
        if (o_data.size() != 16)
            $display("FAIL postreset_count: got %0d want 16", o_data.size());
        else begin
            n_pass++;
            for (int j = 0; j < 16; j++) begin
                n_total++;
                if (o_idx[j] !== exp_idx(j) || o_data[j] !== exp_x[exp_idx(j)])
                    $display("FAIL postreset_out%0d: idx=%h data=%h want idx=%h data=%h", j, o_idx[j], o_data[j], exp_idx(j), exp_x[exp_idx(j)]);
                else n_pass++;
            end
        end
        n_total++;
        if (!got_done || done_cyc != l_cyc + 144)
            $display("FAIL postreset_done: got L+%0d want L+144", done_cyc - l_cyc);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int first_out;
        set_impulse();
        run_frame(1'b1);
        first_out = (o_cyc.size() > 0) ? o_cyc[0] : -1000;
        set_alt();
        run_frame(1'b1);
        n_total++;
        if (o_cyc.size() != 16 || o_cyc[0] != first_out + 160)
            $display("FAIL b2b_period: got %0d outputs, gap %0d want 16, 160", o_cyc.size(), (o_cyc.size() > 0) ? o_cyc[0] - first_out : -1);
        else n_pass++;
        if (o_data.size() == 16) begin
            for (int j = 0; j < 16; j++) begin
                n_total++;
                if (o_idx[j] !== exp_idx(j) || o_data[j] !== exp_x[exp_idx(j)])
                    $display("FAIL b2b_out%0d: idx=%h data=%h want idx=%h data=%h", j, o_idx[j], o_data[j], exp_idx(j), exp_x[exp_idx(j)]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_impulse();
        test_dc();
        test_alternating();
        test_protocol();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fft16_ctrl.md
# fft16_ctrl

Sequencer that owns the shared radix-2 butterfly processing element (PE) and drives it through a complete 16-point decimation-in-frequency FFT. It accepts 16 real samples, holds them in a 16×32-bit in-place working memory, and issues the 32 butterflies (4 stages × 8) one at a time to the PE. It then streams the 16 complex results out. It sits between the sample front end and the result output stage; the PE is instantiated beside it and is not owned by it.

## Interface
- No parameters: N=16 and the data format are fixed.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  sample strobe
- in_data  in  16  real sample, two's complement; imaginary part is taken as 0
- in_ready  out  1  high only in LOAD
- pe_ab_valid  out  1  one-cycle butterfly launch to PE
- pe_a, pe_b  out  32  operands {real[31:16], imag[15:0]}
- pe_const_real, pe_const_imag  out  32  twiddle W16^k, Q16.16 signed
- pe_fft_a, pe_fft_b  in  32  PE results (a+b, (a−b)·W), packed as for the operands
- pe_valid  in  1  PE result strobe
- out_valid  out  1  result strobe
- out_data  out  32  result X[k] {real, imag}
- out_index  out  4  k of the current out_data
- done  out  1  one-cycle pulse with the last result

## Operation
- States: LOAD, ISSUE, WAIT, OUT.
- **LOAD**
  - in_ready=1.
  - Each in_valid cycle writes mem[cnt] = {in_data, 16'h0} and increments cnt.
  - On the 16th accepted sample: go to ISSUE, stage=0, bf=0.
- **ISSUE** (one cycle)
  - span = 8>>stage; group = bf/span; pos = bf%span.
  - top = 2·span·group + pos; bot = top + span; k = pos<<stage.
  - Drive pe_a=mem[top], pe_b=mem[bot], twiddle k, pe_ab_valid=1.
  - Go to WAIT.
- **WAIT**
  - Hold the operands and twiddle stable; pe_ab_valid=0.
  - On pe_valid: mem[top] ← pe_fft_a, mem[bot] ← pe_fft_b.
  - Advance bf; wrap bf 7→0 with stage+1.
  - After stage 3, bf 7, go to OUT; otherwise go to ISSUE.
- **OUT**
  - 16 consecutive cycles, cnt 0..15.
  - out_valid=1, out_index=cnt, out_data per Configuration.
  - done=1 at cnt=15; then go to LOAD.
- Arithmetic is entirely in the PE: 16-bit wrap-around, and the twiddle product is truncated to product[31:16]. The controller does no scaling or saturation.
- in_valid outside LOAD is ignored and the sample is dropped; no error flag is raised.
- pe_valid outside WAIT is ignored.
- The controller never asserts pe_ab_valid while a PE operation is outstanding.

## Timing
- Reset values:
  - state=LOAD, cnt=0, stage=0, bf=0, mem cleared.
  - in_ready=1; all other outputs 0.
- Let L be the cycle in which the 16th sample is accepted.
- First ISSUE occurs at L+1.
- Per butterfly, with the PE's fixed 3-cycle latency:
  - ISSUE at t; pe_valid at t+3; write-back at the t+3 edge; next ISSUE at t+4.
  - Total: 4 cycles per butterfly, 128 cycles of compute (L+1..L+128).
- Output runs L+129..L+144, with done at L+144; in_ready=1 again from L+145.
- A back-to-back stream therefore needs 16 + 144 = 160 cycles per frame.
- Write-back and the next ISSUE memory read never fall in the same cycle, so no bypass is required.
- Reset mid-frame aborts the frame immediately: no outputs are produced and the FSM restarts in LOAD with cnt=0.

## Configuration
- Macro: FFT16_CTRL_BITREV_EN.
- Defined: out_data = mem[bitrev4(cnt)], so results leave in natural order and out_index = k.
- Undefined: out_data = mem[cnt], so results leave in memory (bit-reversed) order, and out_index = bitrev4(cnt) so it still reports the true k.
- Cycle timing is identical in both builds.

## Structure
- Package fft16_pkg:
  - State enum.
  - N=16 and LOG2N=4.
  - 8-entry twiddle ROM constants: W^k = {cos, −sin}(2πk/16)·65536. Examples: k=0 → 0x00010000/0x00000000; k=1 → 0x0000EC83/0xFFFF9E08; k=4 → 0x00000000/0xFFFF0000.
  - bitrev4 function.
- One natural sub-module: fft16_addr_gen, a combinational map (stage, bf) → (top, bot, k).
- The memory is a register array inside the controller.
- The bench instantiates the real PE together with fft16_ctrl.

## Test plan
- Impulse: x[0]=0x0100, all other samples 0 → every out_data=0x01000000, out_index 0..15, done at L+144.
- DC: 16× 0x0100 → X[0]=0x10000000, all other results 0x00000000.
- Alternating: 0x0100 / 0xFF00 samples → X[8]=0x10000000, all others 0; check the order with and without FFT16_CTRL_BITREV_EN.
- Protocol:
  - in_valid held high during compute and OUT → samples dropped, results unchanged.
  - Exactly 32 pe_ab_valid pulses, spaced 4 cycles apart.
- Reset at L+60 → all outputs at reset values; the next frame (impulse) completes correctly.
- Back-to-back: two frames streamed with in_valid held high → second frame's first out_valid at exactly 160 cycles after the first frame's.
